uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Schedules one shared UART transmitter between NUM_REQ byte sources.
- Picks a requester (round-robin by default) and captures its byte.
- Drives the transmitter's two-step handshake: byte_ready to load the byte, then t_byte to start the frame.
- Waits for the frame to finish, then enforces a programmable idle gap before the next grant.
- Sits between the command/data producers and the UART TX FSM/datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width per requester.
- GAP_CYCLES, 16, idle clocks inserted after each frame (0 = no gap).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester send request; held high, with data stable, until ack.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i uses bits [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-cycle pulse; byte of that requester captured.
- tx_done  in  1  one-cycle pulse from transmitter: stop bit complete.
- tx_data  out  DATA_W  registered byte presented to transmitter.
- byte_ready  out  1  one-cycle load strobe to transmitter.
- t_byte  out  1  one-cycle start-transmit strobe.
- grant_id  out  $clog2(NUM_REQ)  index of current or last granted requester.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, all outputs 0, rr pointer=NUM_REQ-1 (so requester 0 wins first), gap counter=0.
- States: IDLE, LOAD, START, BUSY, GAP.
- IDLE
  - Evaluates req combinationally.
  - If any bit is set: latch winner into grant_id, capture its byte into tx_data, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle): byte_ready=1, ack[grant_id]=1, rr pointer=grant_id; go to START.
- START (1 cycle): t_byte=1; go to BUSY.
- BUSY: wait for tx_done=1.
  - If GAP_CYCLES=0, go to IDLE.
  - Otherwise load counter=GAP_CYCLES-1 and go to GAP.
- GAP: decrement counter each cycle; at 0 go to IDLE.
- Latency: req high in IDLE at cycle N gives LOAD at N+1 (byte_ready, ack) and START at N+2 (t_byte).
- Minimum frame-to-frame spacing is tx_done + GAP_CYCLES + 1 (IDLE) + 1 (LOAD) cycles.
- Round-robin: search starts at rr+1 and wraps modulo NUM_REQ. First set bit wins.
- tx_data and grant_id hold their value after the frame until the next capture.
- Boundary conditions:
  - req changes while not IDLE: ignored. Arbitration happens only in IDLE.
  - Requester drops req before ack: not served; no ack issued.
  - Requester still high after ack: treated as a new request at the next IDLE.
  - tx_done outside BUSY (including START): ignored.
  - tx_done during the same cycle the FSM enters BUSY: not possible by construction, because BUSY samples from the cycle after START.
  - All req high continuously: strict rotation 0,1,2,3,0,… with no starvation.
  - Reset mid-frame: immediate return to IDLE, strobes deasserted, pointer reinitialised. No ack is reissued.
  - byte_ready, t_byte and ack are never high in the same cycle as each other, except ack with byte_ready.

Optional Feature:
- Macro: UART_TX_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The rr pointer is removed and the starvation guarantee is waived.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Single request: req=4'b0100, byte 0xA5 on slot 2.
  - Cycle+1: byte_ready=1, ack=4'b0100, tx_data=0xA5, grant_id=2.
  - Cycle+2: t_byte=1.
  - busy falls GAP_CYCLES cycles after tx_done, then IDLE is re-entered.
- Round-robin: req=4'b1111 held, distinct bytes, tx_done 10 cycles after each t_byte.
  - Grants 0,1,2,3,0.
  - byte_ready pulses spaced 10+GAP_CYCLES+3 cycles.
- Withdrawal: req[1] pulsed during BUSY of requester 0 and dropped before IDLE -> no ack[1]; FSM returns to IDLE.
- Spurious tx_done in IDLE and in START -> no state change; BUSY still waits for the real tx_done.
- Async reset asserted mid-BUSY -> outputs 0 within the same cycle. After release, req=4'b1000|4'b0001 grants requester 0 first.
- GAP_CYCLES=0 build -> BUSY goes to IDLE on tx_done; next byte_ready 2 cycles after tx_done. With UART_TX_SCHED_FIXED_PRIO_EN and req=4'b0011 held, requester 0 always wins.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter between NUM_REQ byte sources.
// A winner is picked in IDLE, its byte is captured, and the transmitter is
// driven through a load strobe (byte_ready) and a start strobe (t_byte).
// The scheduler then waits for tx_done and holds off for GAP_CYCLES clocks
// before it arbitrates again.
// Optional build macro: UART_TX_SCHED_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) in place of round-robin. Without it, round-robin is used.
module uart_tx_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    input  logic                        tx_done,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        byte_ready,
    output logic                        t_byte,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    // The counter only has to hold GAP_CYCLES-1.
    localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_BUSY  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t               state_q;
    logic [ID_W-1:0]      grant_id_q;
    logic [DATA_W-1:0]    tx_data_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic                 byte_ready_q;
    logic                 t_byte_q;
    logic                 busy_q;
    logic [CNT_W-1:0]     gap_cnt_q;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
    logic [ID_W-1:0]      rr_q;
`endif

    logic                 any_req_s;
    logic [ID_W-1:0]      winner_s;
    logic [DATA_W-1:0]    win_data_s;
    logic [NUM_REQ-1:0]   win_onehot_s;

    // Pick the winning requester from the current req vector.
    always_comb begin
        any_req_s = |req;
        winner_s  = '0;
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
        // Walk from the top down so the lowest set index is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            winner_s = req[i] ? ID_W'(i) : winner_s;
        end
`else
        begin : rr_search
            logic found;
            int   idx;
            found = 1'b0;
            idx   = 0;
            // Search starts just after the last grant and wraps around.
            for (int off = 1; off <= NUM_REQ; off++) begin
                idx      = (int'(rr_q) + off) % NUM_REQ;
                winner_s = (!found && req[ID_W'(idx)]) ? ID_W'(idx) : winner_s;
                found    = found | req[ID_W'(idx)];
            end
        end
`endif
    end

    // Select the winner's byte and build its one-hot acknowledge.
    always_comb begin
        win_data_s   = '0;
        win_onehot_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_data_s      = (ID_W'(i) == winner_s) ? req_data[i*DATA_W +: DATA_W] : win_data_s;
            win_onehot_s[i] = (ID_W'(i) == winner_s);
        end
    end

    // Scheduler FSM with registered strobes, capture registers and gap counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= '0;
            tx_data_q    <= '0;
            ack_q        <= '0;
            byte_ready_q <= 1'b0;
            t_byte_q     <= 1'b0;
            busy_q       <= 1'b0;
            gap_cnt_q    <= '0;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
            rr_q         <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    t_byte_q <= 1'b0;
                    if (any_req_s) begin
                        // Strobes are set on entry so they are high during LOAD.
                        state_q      <= ST_LOAD;
                        grant_id_q   <= winner_s;
                        tx_data_q    <= win_data_s;
                        ack_q        <= win_onehot_s;
                        byte_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end else begin
                        state_q      <= ST_IDLE;
                        ack_q        <= '0;
                        byte_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    state_q      <= ST_START;
                    ack_q        <= '0;
                    byte_ready_q <= 1'b0;
                    t_byte_q     <= 1'b1;
                    busy_q       <= 1'b1;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
                    rr_q         <= grant_id_q;
`endif
                end
                ST_START: begin
                    // tx_done is not looked at here; a pulse now is ignored.
                    state_q  <= ST_BUSY;
                    t_byte_q <= 1'b0;
                    busy_q   <= 1'b1;
                end
                ST_BUSY: begin
                    if (tx_done) begin
                        if (GAP_CYCLES == 0) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= ST_GAP;
                            gap_cnt_q <= CNT_W'(GAP_CYCLES - 1);
                            busy_q    <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_BUSY;
                        busy_q  <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q   <= ST_GAP;
                        gap_cnt_q <= gap_cnt_q - CNT_W'(1);
                        busy_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    ack_q        <= '0;
                    byte_ready_q <= 1'b0;
                    t_byte_q     <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign ack        = ack_q;
    assign tx_data    = tx_data_q;
    assign byte_ready = byte_ready_q;
    assign t_byte     = t_byte_q;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a table of frames plus hand-written
// sequences for spurious tx_done, withdrawal, async reset and a zero-gap build.
module tb_uart_tx_sched;

    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req,  ack;
    logic [31:0] req_data;
    logic        tx_done;
    logic [7:0]  tx_data;
    logic        byte_ready, t_byte, busy;
    logic [1:0]  grant_id;

    logic [3:0]  req0, ack0;
    logic [31:0] req_data0;
    logic        tx_done0;
    logic [7:0]  tx_data0;
    logic        byte_ready0, t_byte0, busy0;
    logic [1:0]  grant_id0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_br = 0;

    uart_tx_sched #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(GAP)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .tx_done(tx_done), .tx_data(tx_data), .byte_ready(byte_ready),
        .t_byte(t_byte), .grant_id(grant_id), .busy(busy)
    );

    uart_tx_sched #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req0), .req_data(req_data0), .ack(ack0),
        .tx_done(tx_done0), .tx_data(tx_data0), .byte_ready(byte_ready0),
        .t_byte(t_byte0), .grant_id(grant_id0), .busy(busy0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [1:0]  g_rr;
        logic [1:0]  g_fp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] pick(input logic [1:0] g_rr, input logic [1:0] g_fp);
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
        return g_fp;
`else
        return g_rr;
`endif
    endfunction

    // One full frame; starts and ends at a negedge in IDLE.
    task automatic run_frame(input logic [3:0] r, input logic [31:0] d, input logic [1:0] g,
                             input bit spur, input bit chk_space, input string tag);
        int n;
        req = r;
        req_data = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!byte_ready && n < 60);
        chk({tag, " byte_ready"}, 32'(byte_ready), 32'd1);
        if (!byte_ready) return;
        if (chk_space) chk({tag, " spacing"}, 32'(cyc - last_br), 32'(13 + GAP));
        last_br = cyc;
        chk({tag, " ack"}, 32'(ack), 32'(4'b0001 << g));
        chk({tag, " grant_id"}, 32'(grant_id), 32'(g));
        chk({tag, " tx_data"}, 32'(tx_data), 32'(8'(d >> (8 * g))));
        chk({tag, " t_byte in LOAD"}, 32'(t_byte), 32'd0);
        @(negedge clk);
        chk({tag, " START strobes"}, 32'({t_byte, byte_ready, ack}), 32'(6'b100000));
        if (spur) begin
            tx_done = 1'b1;
            @(posedge clk); #1 tx_done = 1'b0;
            repeat (9) @(posedge clk);
        end else begin
            repeat (10) @(posedge clk);
        end
        #1 tx_done = 1'b1;
        @(negedge clk);
        chk({tag, " busy before tx_done"}, 32'(busy), 32'd1);
        @(posedge clk); #1 tx_done = 1'b0;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " gap length"}, 32'(n), 32'(GAP));
    endtask

    initial begin
        int n;
        int t_done;
        logic [3:0] ack_seen;
        logic [1:0] g0 [3];
        rst = 1'b0; req = '0; req_data = '0; tx_done = 1'b0;
        req0 = '0; req_data0 = '0; tx_done0 = 1'b0;

        vecs[0] = '{4'b1111, 32'h44332211, 2'd0, 2'd0};
        vecs[1] = '{4'b1111, 32'h88776655, 2'd1, 2'd0};
        vecs[2] = '{4'b1111, 32'hCCBBAA99, 2'd2, 2'd0};
        vecs[3] = '{4'b1111, 32'h1F2E3D4C, 2'd3, 2'd0};
        vecs[4] = '{4'b1111, 32'h5B6A7988, 2'd0, 2'd0};
        vecs[5] = '{4'b0100, 32'h11A52233, 2'd2, 2'd2};
        vecs[6] = '{4'b1010, 32'hDEADBEEF, 2'd3, 2'd1};
        vecs[7] = '{4'b1010, 32'hCAFEF00D, 2'd1, 2'd1};
        vecs[8] = '{4'b0011, 32'h0F1E2D3C, 2'd0, 2'd0};
        vecs[9] = '{4'b0011, 32'h96877869, 2'd1, 2'd0};

        repeat (3) @(negedge clk);
        chk("reset outputs", 32'({busy, byte_ready, t_byte, ack, grant_id, tx_data}), 32'd0);
        rst = 1'b1;

        // Table-driven frames; req stays set between frames, so spacing is minimal.
        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i].req, vecs[i].data, pick(vecs[i].g_rr, vecs[i].g_fp),
                      1'b0, (i > 0), $sformatf("vec%0d", i));
        end

        // Spurious tx_done in IDLE: nothing happens.
        req = '0;
        tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
        @(negedge clk);
        chk("spurious idle", 32'({busy, byte_ready}), 32'd0);

        // Spurious tx_done in START: BUSY still waits for the real one (rr=1 -> 2).
        run_frame(4'b0100, 32'h00A50000, 2'd2, 1'b1, 1'b0, "spur_start");

        // Withdrawal: req[1] pulsed during requester 0's BUSY, dropped before IDLE.
        req = 4'b0001;
        req_data = 32'h33221100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!byte_ready && n < 60);
        chk("withdraw grant", 32'({byte_ready, grant_id}), 32'(3'b100));
        @(posedge clk); #1 req = '0;
        repeat (4) @(posedge clk);
        #1 req = 4'b0010;
        repeat (3) @(posedge clk);
        #1 req = '0;
        repeat (2) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
        ack_seen = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            ack_seen = ack_seen | ack;
        end
        chk("withdraw no ack", 32'(ack_seen), 32'd0);
        chk("withdraw idle", 32'(busy), 32'd0);

        // Async reset mid-BUSY (rr=0, req 0010 -> 1 in both builds).
        req = 4'b0010;
        req_data = 32'h77665544;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!byte_ready && n < 60);
        chk("pre-reset grant", 32'({byte_ready, grant_id}), 32'(3'b101));
        req = '0;
        @(negedge clk);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("async reset outputs", 32'({busy, byte_ready, t_byte, ack, grant_id, tx_data}), 32'd0);
        req = 4'b1001;
        @(negedge clk);
        rst = 1'b1;
        run_frame(4'b1001, 32'h9A000055, 2'd0, 1'b0, 1'b0, "post_reset");
        req = '0;

        // Zero-gap instance: next byte_ready two cycles after tx_done.
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
        g0[0] = 2'd0; g0[1] = 2'd0; g0[2] = 2'd0;
`else
        g0[0] = 2'd0; g0[1] = 2'd1; g0[2] = 2'd0;
`endif
        req0 = 4'b0011;
        req_data0 = 32'h0000B2C1;
        t_done = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!byte_ready0 && n < 60);
            chk($sformatf("gap0 f%0d grant", k), 32'({byte_ready0, grant_id0}), 32'({1'b1, g0[k]}));
            if (k > 0) chk($sformatf("gap0 f%0d spacing", k), 32'(cyc - t_done), 32'd2);
            chk($sformatf("gap0 f%0d tx_data", k), 32'(tx_data0), 32'(8'(req_data0 >> (8 * g0[k]))));
            @(negedge clk);
            chk($sformatf("gap0 f%0d t_byte", k), 32'(t_byte0), 32'd1);
            repeat (10) @(posedge clk);
            #1 tx_done0 = 1'b1;
            @(negedge clk);
            t_done = cyc;
            @(posedge clk); #1 tx_done0 = 1'b0;
        end
        req0 = '0;
        repeat (3) @(negedge clk);
        chk("gap0 idle", 32'(busy0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
